fanout_fork_buffer: RTL and testbench

FANOUT_FORK_BUFFER -- requirements
Module: fanout_fork_buffer

---
 rtl/fanout_fork_if.sv | 24 ++
 rtl/fanout_fork_buffer.sv | 81 ++++++++
 tb/tb_fanout_fork_buffer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fanout_fork_if.sv
// Producer/consumer handshake bundle for fanout_fork_buffer.
// The master modport is the side that drives tokens in and consumes them. The slave modport is the buffer.
interface fanout_fork_if #(
  parameter int NUM_OUT = 6,
  parameter int DATA_W  = 16
);
  logic [DATA_W-1:0]  in_data;
  logic [NUM_OUT-1:0] in_dest;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;

  modport master (
    output in_data, in_dest, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_dest, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fanout_fork_buffer.sv
// Single-token eager fork: one held payload is delivered once to each selected consumer channel.
// Define FANOUT_FORK_PERF_CNT_EN to add saturating stall_cnt/drop_cnt outputs.
module fanout_fork_buffer #(
  parameter int NUM_OUT = 6,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [NUM_OUT-1:0] cfg_enable,
  fanout_fork_if.slave       bus
`ifdef FANOUT_FORK_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [15:0]        drop_cnt
`endif
);

  logic               full;
  logic [NUM_OUT-1:0] pending;
  logic [DATA_W-1:0]  data_q;

  logic [NUM_OUT-1:0] out_vld;
  logic [NUM_OUT-1:0] pending_after;
  logic [NUM_OUT-1:0] eff_mask;
  logic               ready_int;
  logic               accept;

  always_comb begin
    out_vld       = {NUM_OUT{full}} & pending;
    pending_after = pending & ~(out_vld & bus.out_ready);
    eff_mask      = bus.in_dest & cfg_enable;
    // Ready when every still-pending channel is taking its copy this cycle.
    // This gives a combinational path from out_ready to in_ready.
    ready_int     = rst_n & ~flush & (~full | ~|(pending & ~bus.out_ready));
    accept        = bus.in_valid & ready_int;
  end

  assign bus.in_ready  = ready_int;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = data_q;

  // NOTE: the payload register is reset as well as the control bits, so out_data
  // reads 0 after reset. It holds a single word, so the reset costs almost nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 1'b0;
      pending <= '0;
      data_q  <= '0;
    end else if (flush) begin
      full    <= 1'b0;
      pending <= '0;
    end else if (accept && (eff_mask != '0)) begin
      full    <= 1'b1;
      pending <= eff_mask;
      data_q  <= bus.in_data;
    end else if (accept) begin
      // A zero-mask token is dropped. Acceptance implies the previous token has drained.
      full    <= 1'b0;
      pending <= '0;
    end else begin
      full    <= |pending_after;
      pending <= pending_after;
    end
  end

`ifdef FANOUT_FORK_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (bus.in_valid && !ready_int && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (accept && (eff_mask == '0) && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fanout_fork_buffer.sv
// Directed self-checking bench for fanout_fork_buffer with NUM_OUT=6 and DATA_W=16.
// Inputs change on the falling edge, and outputs are checked 1 ns later.
module tb_fanout_fork_buffer;
  localparam int NUM_OUT = 6;
  localparam int DATA_W  = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic [NUM_OUT-1:0] cfg_enable;
`ifdef FANOUT_FORK_PERF_CNT_EN
  logic [31:0]        stall_cnt;
  logic [15:0]        drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fanout_fork_if #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W)) bus ();

  fanout_fork_buffer #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .cfg_enable (cfg_enable),
    .bus        (bus.slave)
`ifdef FANOUT_FORK_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge, apply the inputs, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [15:0] d, input logic [5:0] dest,
                       input logic [5:0] rdy, input logic [5:0] cfg, input logic fl);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_dest   = dest;
    bus.out_ready = rdy;
    cfg_enable    = cfg;
    flush         = fl;
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    cfg_enable    = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_dest   = '0;
    bus.out_ready = '0;

    // Behaviour while reset is held and on the first cycle after release.
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Four back-to-back broadcast tokens.
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'hA1 + 16'(i), 6'h3F, 6'h3F, 6'h3F, 0);
      check("b2b_in_ready", bus.in_ready, 1);
      if (i == 0) check("b2b_latency", bus.out_valid, 0);
      else begin
        check("b2b_out_valid", bus.out_valid, 6'h3F);
        check("b2b_out_data", bus.out_data, 16'hA1 + 16'(i) - 16'd1);
      end
    end
    drive(0, 0, 0, 6'h3F, 6'h3F, 0);
    check("b2b_last_valid", bus.out_valid, 6'h3F);
    check("b2b_last_data", bus.out_data, 16'hA4);
    drive(0, 0, 0, 6'h3F, 6'h3F, 0);
    check("b2b_drained", bus.out_valid, 0);

    // One slow consumer, then a new token loaded with no bubble.
    drive(1, 16'hB1, 6'h05, 6'h01, 6'h3F, 0);
    check("slow_accept", bus.in_ready, 1);
    drive(0, 0, 0, 6'h01, 6'h3F, 0);
    check("slow_ov_c1", bus.out_valid, 6'h05);
    check("slow_rdy_c1", bus.in_ready, 0);
    drive(0, 0, 0, 6'h01, 6'h3F, 0);
    check("slow_ov_c2", bus.out_valid, 6'h04);
    check("slow_rdy_c2", bus.in_ready, 0);
    drive(0, 0, 0, 6'h01, 6'h3F, 0);
    check("slow_ov_c3", bus.out_valid, 6'h04);
    check("slow_rdy_c3", bus.in_ready, 0);
    drive(1, 16'hB2, 6'h01, 6'h05, 6'h3F, 0);
    check("slow_ov_c4", bus.out_valid, 6'h04);
    check("slow_rdy_c4", bus.in_ready, 1);
    drive(0, 0, 0, 6'h3F, 6'h3F, 0);
    check("nobubble_ov", bus.out_valid, 6'h01);
    check("nobubble_data", bus.out_data, 16'hB2);
    drive(0, 0, 0, 6'h3F, 6'h3F, 0);
    check("nobubble_drained", bus.out_valid, 0);

    // A token whose effective mask is zero is dropped.
    drive(1, 16'hC0, 6'h0F, 6'h3F, 6'h30, 0);
    check("drop_in_ready", bus.in_ready, 1);
    drive(0, 0, 0, 6'h3F, 6'h30, 0);
    check("drop_out_valid", bus.out_valid, 0);
    check("drop_in_ready_after", bus.in_ready, 1);
`ifdef FANOUT_FORK_PERF_CNT_EN
    check("drop_cnt", drop_cnt, 1);
`endif

    // Flush overrides a simultaneous acceptance.
    drive(1, 16'hC1, 6'h03, 6'h00, 6'h3F, 0);
    drive(0, 0, 0, 6'h00, 6'h3F, 0);
    check("flush_held_ov", bus.out_valid, 6'h03);
    check("flush_held_rdy", bus.in_ready, 0);
    drive(1, 16'hC2, 6'h3F, 6'h00, 6'h3F, 1);
    check("flush_in_ready", bus.in_ready, 0);
    drive(0, 0, 0, 6'h00, 6'h3F, 0);
    check("flush_cleared_ov", bus.out_valid, 0);
    check("flush_rdy_after", bus.in_ready, 1);
    drive(0, 0, 0, 6'h00, 6'h3F, 0);
    check("flush_no_load", bus.out_valid, 0);
`ifdef FANOUT_FORK_PERF_CNT_EN
    check("stall_cnt", stall_cnt, 1);
`endif

    // Reset asserted in the middle of a delivery.
    drive(1, 16'hD1, 6'h06, 6'h00, 6'h3F, 0);
    drive(0, 0, 0, 6'h00, 6'h3F, 0);
    check("midrst_held_ov", bus.out_valid, 6'h06);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ov_async", bus.out_valid, 0);
    check("midrst_rdy_async", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_rdy_post", bus.in_ready, 1);
    drive(0, 0, 0, 6'h3F, 6'h3F, 0);
    check("midrst_no_replay", bus.out_valid, 0);
`ifdef FANOUT_FORK_PERF_CNT_EN
    check("midrst_drop_cnt", drop_cnt, 0);
`endif

    // A cfg_enable change does not re-mask a held token.
    drive(1, 16'hE1, 6'h3F, 6'h00, 6'h3F, 0);
    drive(0, 0, 0, 6'h00, 6'h01, 0);
    check("cfg_held_ov", bus.out_valid, 6'h3F);
    check("cfg_held_rdy", bus.in_ready, 0);
    drive(1, 16'hE2, 6'h3F, 6'h3F, 6'h01, 0);
    check("cfg_still_all", bus.out_valid, 6'h3F);
    check("cfg_rdy", bus.in_ready, 1);
    drive(0, 0, 0, 6'h3F, 6'h01, 0);
    check("cfg_next_ch0", bus.out_valid, 6'h01);
    check("cfg_next_data", bus.out_data, 16'hE2);
    drive(0, 0, 0, 6'h3F, 6'h01, 0);
    check("cfg_drained", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
